// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (instruction/data) arbiter onto one DRAM request port.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise m1 wins ties.
module mem_arbiter #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_cs,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack,
  input  logic                  m1_cs,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_cs,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack
);
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic grant;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign grant = (m0_cs && m1_cs) ? ~last_q : m1_cs;
`else
  assign grant = m1_cs;
`endif
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d = we_q;
    addr_d = addr_q;
    data_d = data_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d = last_q;
`endif
    case (state_q)
      IDLE: if (m0_cs || m1_cs) begin
        state_d = BUSY;
        owner_d = grant;
        we_d = grant ? m1_we : m0_we;
        addr_d = grant ? m1_addr : m0_addr;
        data_d = grant ? m1_data_i : m0_data_i;
`ifdef ARB_ROUND_ROBIN_EN
        last_d = grant;
`endif
      end
      BUSY: state_d = mem_ack ? RELEASE : BUSY;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q <= last_d;
`endif
    end
  end
  // mem_ack only counts while a transaction is outstanding
  assign mem_cs = state_q == BUSY;
  assign mem_we = mem_cs & we_q;
  assign mem_addr = addr_q;
  assign mem_data_o = data_q;
  assign m0_ack = mem_cs & mem_ack & ~owner_q;
  assign m1_ack = mem_cs & mem_ack & owner_q;
  assign m0_data_o = mem_data_i;
  assign m1_data_o = mem_data_i;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random transactions against a DRAM model with a 10-cycle delay.
module tb_mem_arbiter;
  localparam int DW = 256;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic rst;
  logic m0_cs, m0_we, m1_cs, m1_we;
  logic [AW-1:0] m0_addr, m1_addr, mem_addr;
  logic [DW-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o;
  logic m0_ack, m1_ack;
  logic [DW-1:0] mem_data_o, mem_data_i;
  logic mem_cs, mem_we, mem_ack, dram_ack, inj_ack;
  logic [DW-1:0] dram [64];
  logic [DW-1:0] ref_mem [64];
  int total = 0;
  int bad = 0;
  int cnt;
  bit last_m;
  bit p [2];
  bit quiet;
  bit g;

  always #5 clk = ~clk;
  assign mem_ack = dram_ack | inj_ack;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_cs(m0_cs), .m0_we(m0_we), .m0_addr(m0_addr), .m0_data_i(m0_data_i),
    .m0_data_o(m0_data_o), .m0_ack(m0_ack),
    .m1_cs(m1_cs), .m1_we(m1_we), .m1_addr(m1_addr), .m1_data_i(m1_data_i),
    .m1_data_o(m1_data_o), .m1_ack(m1_ack),
    .mem_addr(mem_addr), .mem_data_o(mem_data_o), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_data_i(mem_data_i), .mem_ack(mem_ack)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return {8{32'hCAFE0000 + 32'(i)}};
  endfunction

  // arbitration rule: lone requester wins; on a tie RR picks the one not served last, else m1
  function automatic bit pick(input bit c0, input bit c1);
`ifdef ARB_ROUND_ROBIN_EN
    return (c0 && c1) ? !last_m : c1;
`else
    return c1 | (c0 & 1'b0);
`endif
  endfunction

  // DRAM: acks on the 10th consecutive cycle of mem_cs, one-cycle pulse
  initial begin
    for (int i = 0; i < 64; i++) dram[i] = init_val(i);
    cnt = 0;
    dram_ack = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      dram_ack = 1'b0;
      if (mem_cs !== 1'b1) cnt = 0;
      else begin
        cnt++;
        if (cnt == 10) begin
          dram_ack = 1'b1;
          if (mem_we) dram[mem_addr[10:5]] = mem_data_o;
          mem_data_i = dram[mem_addr[10:5]];
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit m, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    if (m) begin m1_cs = 1'b1; m1_addr = a; m1_we = w; m1_data_i = d; end
    else begin m0_cs = 1'b1; m0_addr = a; m0_we = w; m0_data_i = d; end
  endtask

  task automatic run_txn(input bit m, input int exp_lat, input int drop_at, input bit keep);
    logic [AW-1:0] a;
    logic w;
    logic [DW-1:0] d;
    int n, lat;
    bit stable, got;
    a = m ? m1_addr : m0_addr;
    w = m ? m1_we : m0_we;
    d = m ? m1_data_i : m0_data_i;
    lat = 0; n = 0; stable = 1'b1; got = 1'b0;
    @(negedge clk);
    while (mem_cs !== 1'b1 && lat < 5) begin lat++; @(negedge clk); end
    chk("grant_lat", lat, exp_lat);
    chk("mem_addr", mem_addr, a);
    chk("mem_we", mem_we, w);
    if (w) chk("mem_wdata", mem_data_o, d);
    while (!got && n < 30) begin
      n++;
      if (mem_addr !== a || mem_we !== w) stable = 1'b0;
      if (m0_ack || m1_ack) got = 1'b1;
      else begin
        if (n == drop_at) begin if (m) m1_cs = 1'b0; else m0_cs = 1'b0; end
        @(negedge clk);
      end
    end
    chk("ack_seen", got, 1);
    chk("ack_owner", {m1_ack, m0_ack}, m ? 2'b10 : 2'b01);
    chk("busy_len", n, 10);
    chk("addr_stable", stable, 1);
    if (w) ref_mem[a[10:5]] = d;
    else chk("rdata", m ? m1_data_o : m0_data_o, ref_mem[a[10:5]]);
    if (!keep) begin if (m) m1_cs = 1'b0; else m0_cs = 1'b0; end
    @(negedge clk);
    chk("rel_cs", mem_cs, 0);
    chk("rel_we", mem_we, 0);
    chk("rel_ack", {m1_ack, m0_ack}, 0);
  endtask

  initial begin
    logic [DW-1:0] d;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    rst = 1'b1; inj_ack = 1'b0; last_m = 1'b0;
    m0_cs = 0; m0_we = 0; m0_addr = '0; m0_data_i = '0;
    m1_cs = 0; m1_we = 0; m1_addr = '0; m1_data_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs", mem_cs, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data_o, 0);
    chk("rst_ack", {m1_ack, m0_ack}, 0);
    rst = 1'b0;
    // m0 read alone
    set_req(0, 32'h20, 0, '0);
    last_m = pick(1, 0);
    run_txn(0, 0, -1, 0);
    // m1 write, then read back through m0
    set_req(1, 32'h400, 1, 256'h5);
    last_m = pick(0, 1);
    run_txn(1, 1, -1, 0);
    chk("dram_wr", dram[32], 256'h5);
    set_req(0, 32'h400, 0, '0);
    last_m = pick(1, 0);
    run_txn(0, 1, -1, 0);
    // both held high across three transactions
    set_req(0, 32'h40, 0, '0);
    set_req(1, 32'h60, 0, '0);
    for (int k = 0; k < 3; k++) begin
      g = pick(1, 1);
      last_m = g;
      run_txn(g, 1, -1, 1);
    end
    m0_cs = 0; m1_cs = 0;
    // reset four cycles into BUSY
    set_req(0, 32'h80, 0, '0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", mem_cs, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1; m0_cs = 1'b0;
    @(negedge clk);
    chk("rst_busy_cs", mem_cs, 0);
    chk("rst_busy_addr", mem_addr, 0);
    rst = 1'b0; last_m = 1'b0; quiet = 1'b1;
    for (int k = 0; k < 12; k++) begin
      inj_ack = (k == 1);
      #1;
      if (m0_ack || m1_ack || mem_cs) quiet = 1'b0;
      @(negedge clk);
    end
    inj_ack = 1'b0;
    chk("rst_quiet", quiet, 1);
    set_req(1, 32'hA0, 0, '0);
    last_m = pick(0, 1);
    run_txn(1, 0, -1, 0);
    // m1 drops cs mid-BUSY
    set_req(1, 32'hC0, 1, {8{32'h600DF00D}});
    last_m = pick(0, 1);
    run_txn(1, 1, 3, 0);
    // random traffic
    p[0] = 0; p[1] = 0;
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 2; k++)
        if (!p[k] && ($urandom_range(1, 0) == 1 || (k == 1 && !p[0] && !p[1]))) begin
          for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom;
          set_req(k[0], AW'($urandom_range(63, 0)) << 5, 1'($urandom_range(1, 0)), d);
          p[k] = 1;
        end
      g = pick(p[0], p[1]);
      last_m = g;
      run_txn(g, 1, -1, 0);
      p[g] = 0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, memory line width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 m0_cs / m0_we  in  1/1  instruction-side request and write enable.
REQ-007 m0_addr / m0_data_i  in  ADDR_WIDTH/DATA_WIDTH  instruction-side address and write data.
REQ-008 m0_data_o / m0_ack  out  DATA_WIDTH/1  read data and completion pulse to the instruction side.
REQ-009 m1_cs, m1_we, m1_addr, m1_data_i, m1_data_o, m1_ack: same widths and meaning for the data-cache side.
REQ-010 mem_addr / mem_data_o / mem_cs / mem_we  out  ADDR_WIDTH/DATA_WIDTH/1/1  shared DRAM request port.
REQ-011 mem_data_i / mem_ack  in  DATA_WIDTH/1  DRAM read data and one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, RELEASE; owner register selects m0 or m1.
REQ-013 IDLE: with no mN_cs high, SHALL stay in IDLE with mem_cs=0.
REQ-014 IDLE: with any mN_cs high, SHALL pick an owner, latch its addr/we/data_i into mem_addr/mem_we/mem_data_o, and enter BUSY next cycle.
REQ-015 BUSY: SHALL drive mem_cs=1; latched outputs SHALL stay stable until mem_ack.
REQ-016 BUSY with mem_ack=1: SHALL assert owner's mN_ack combinationally in the same cycle, then enter RELEASE.
REQ-017 RELEASE: SHALL drive mem_cs=0 and mem_we=0 for exactly one cycle, ignore all mN_cs, then return to IDLE.
REQ-018 m0_data_o and m1_data_o SHALL both equal mem_data_i; a master treats them as valid only when its ack is 1.
REQ-019 Non-owner mN_ack SHALL be 0 at all times; mem_ack outside BUSY SHALL be ignored.
REQ-020 A master deasserting cs during BUSY SHALL NOT abort the transaction; the ack pulse SHALL still be issued.
REQ-021 Latency: request sampled in IDLE at cycle T; mem_cs=1 from T+1; ack forwarded on the cycle of mem_ack; earliest next grant 2 cycles after ack.
REQ-022 A new request arriving during BUSY or RELEASE SHALL be held pending by the master (cs kept high) and served from IDLE.

Reset
REQ-023 rst=1 SHALL force state=IDLE, mem_cs=0, mem_we=0, mem_addr=0, mem_data_o=0, m0_ack=m1_ack=0, last-grant=m0.
REQ-024 rst during BUSY SHALL abandon the transaction with no ack; a mem_ack arriving after reset SHALL be ignored.

Configuration
REQ-025 ARB_ROUND_ROBIN_EN defined: with both cs high in IDLE, SHALL grant the master not served last; last-grant updates on each grant.
REQ-026 ARB_ROUND_ROBIN_EN undefined: with both cs high, SHALL always grant m1 (data side); last-grant register absent.

Verification (DRAM model, delay 10)
REQ-027 m0 read 0x0020 alone -> mem_cs high 1 cycle later, mem_addr=0x0020, m0_ack one pulse after 10 cycles, m0_data_o=memory[1], m1_ack stays 0.
REQ-028 m1 write 0x0400 data 256'h5 -> mem_we=1, memory[32]=5 after ack; RELEASE cycle shows mem_cs=0.
REQ-029 m0 and m1 both request in same cycle, both held high, RR enabled -> grants m1, m0, m1 on three consecutive transactions; RR disabled -> m1 starves m0 while m1 stays high.
REQ-030 rst pulsed 4 cycles into BUSY -> mem_cs=0 next cycle, no mN_ack pulse, late mem_ack ignored, next request served normally.
REQ-031 m1 drops cs mid-BUSY -> transaction completes, m1_ack still pulses once, mem_addr unchanged throughout.
